key_schedule_ctrl: RTL and testbench
====================================

Name: key_schedule_ctrl

Overview:
Controller that sequences per-cycle key values into a state-dependent key-locked core. The locked core expects a different key slice on each phase of its internal modulo-DEPTH counter. This block holds a DEPTH-entry key schedule, loaded over a valid/ready config port, and drives key_out in lock-step with a phase counter once started. It sits between the key-provisioning logic and the locked core's keyinput pins.

Parameters:
KEY_W, 3, width of one key slice (keyinput bus width)
DEPTH, 4, number of schedule entries = phases of the core counter (power of 2, >=2)
IDX_W, 2, log2(DEPTH)
WRAP_W, 16, width of completed-schedule-wrap counter

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high with cfg_valid
cfg_idx  in  IDX_W  schedule entry index
cfg_key  in  KEY_W  key slice to write
cfg_commit  in  1  request to arm the loaded schedule
start  in  1  begin sequencing (pulse)
stop  in  1  end sequencing (pulse)
err_clr  in  1  clear sticky error
key_out  out  KEY_W  key slice to the locked core
key_valid  out  1  key_out is a live schedule value
phase  out  IDX_W  current schedule phase
armed  out  1  schedule complete and committed
busy  out  1  state == RUN
wraps  out  WRAP_W  count of phase DEPTH-1 -> 0 transitions in RUN, saturating
err  out  1  sticky error flag

Behaviour:
- Reset (reset_n=0 at posedge): state LOAD, table all 0, written-mask 0, key_out 0, key_valid 0, phase 0, armed 0, busy 0, wraps 0, err 0. Reset takes effect in any state, including mid-RUN.
- States: LOAD, ARMED, RUN. All outputs are registered.
- cfg_ready = 1 in LOAD and ARMED, 0 in RUN.
- On a write handshake (cfg_valid & cfg_ready), table[cfg_idx] <= cfg_key and mask[cfg_idx] <= 1, effective next cycle.
- A write in ARMED returns the state to LOAD (armed=0). The mask is retained.
- cfg_valid in RUN is ignored (no write) and sets err.
- LOAD -> ARMED: on cfg_commit with the mask all ones, counting a write in the same cycle.
- cfg_commit with an incomplete mask: sets err, state stays LOAD.
- cfg_commit in ARMED or RUN: no effect.
- ARMED -> RUN: on start. The first RUN cycle shows phase=0, key_out=table[0], key_valid=1.
- In RUN, every cycle: phase <= phase+1 modulo DEPTH, key_out <= table[next phase]. The invariant key_out == table[phase] holds every RUN cycle.
- On phase DEPTH-1 -> 0, wraps increments and saturates at all ones. wraps clears on the ARMED -> RUN transition.
- RUN -> ARMED on stop: next cycle key_out=0, key_valid=0, phase=0. wraps holds its value.
- start and stop in the same cycle: stop wins. From ARMED, stay ARMED. From RUN, go to ARMED.
- start outside ARMED: ignored and sets err.
- stop outside RUN: ignored.
- err is set by the events above and cleared by err_clr. A set event in the same cycle as err_clr wins (err=1).
- Outside RUN: key_out=0, key_valid=0.

Test Plan:
1. Reset, then write idx0..3 = 3'b100, 3'b000, 3'b011, 3'b110; commit. Expect armed=1 one cycle after commit, err=0.
2. From case 1, pulse start. Expect key_out sequence 100, 000, 011, 110, 100 … with phase 0, 1, 2, 3, 0. wraps=1 after the 5th RUN cycle; busy=1 throughout.
3. Write only idx0..2, then commit. Expect err=1, armed=0, state LOAD. Then write idx3, pulse err_clr, commit. Expect armed=1, err=0.
4. During RUN at phase 2, assert cfg_valid. Expect cfg_ready=0, table unchanged, err=1, sequencing uninterrupted.
5. During RUN, assert start and stop together. Expect ARMED next cycle, key_valid=0, key_out=0, phase=0. A later start restarts at phase 0 with wraps=0.
6. Drop reset_n for one cycle at phase 3 mid-RUN. Expect state LOAD, all outputs 0, mask cleared: an immediate commit sets err=1.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: holds a DEPTH-entry key schedule loaded over a
// valid/ready config port and, once armed and started, drives one key
// slice per cycle in lock-step with a modulo-DEPTH phase counter.
module key_schedule_ctrl #(
  parameter int KEY_W  = 3,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2,
  parameter int WRAP_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic              cfg_commit,
  input  logic              start,
  input  logic              stop,
  input  logic              err_clr,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic [IDX_W-1:0]  phase,
  output logic              armed,
  output logic              busy,
  output logic [WRAP_W-1:0] wraps,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   table_q [DEPTH];
  logic [DEPTH-1:0]   mask_q;

  logic               cfg_ready_q, cfg_ready_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               key_valid_q, key_valid_d;
  logic [IDX_W-1:0]   phase_q, phase_d;
  logic               armed_q, armed_d;
  logic               busy_q, busy_d;
  logic [WRAP_W-1:0]  wraps_q, wraps_d;
  logic               err_q, err_d;

  logic               wr_hs;
  logic [DEPTH-1:0]   wr_onehot;
  logic [DEPTH-1:0]   mask_after;
  logic [IDX_W-1:0]   phase_inc;
  logic               err_set;

  // A write is accepted only while cfg_ready is high, i.e. outside RUN.
  assign wr_hs      = cfg_valid & cfg_ready_q;
  assign wr_onehot  = wr_hs ? (DEPTH'(1) << cfg_idx) : '0;
  // Commit sees the mask including a write landing in the same cycle.
  assign mask_after = mask_q | wr_onehot;
  assign phase_inc  = phase_q + 1'b1;

  // Schedule table and written-mask, one register slice per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the key slice and mark the entry written on a handshake.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        table_q[gi] <= '0;
        mask_q[gi]  <= 1'b0;
      end else if (wr_onehot[gi]) begin
        table_q[gi] <= cfg_key;
        mask_q[gi]  <= 1'b1;
      end
    end
  end

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    key_out_d   = key_out_q;
    phase_d     = phase_q;
    wraps_d     = wraps_q;
    err_set     = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (start) err_set = 1'b1;
        if (cfg_commit) begin
          if (&mask_after) state_d = ST_ARMED;
          else             err_set = 1'b1;
        end
      end

      ST_ARMED: begin
        // A rewrite invalidates the armed schedule; it wins over start so
        // sequencing never begins with a half-updated table.
        if (wr_hs) begin
          state_d = ST_LOAD;
        end else if (start && !stop) begin
          state_d   = ST_RUN;
          phase_d   = '0;
          key_out_d = table_q[0];
          wraps_d   = '0;
        end
      end

      ST_RUN: begin
        if (cfg_valid) err_set = 1'b1;
        if (start && !stop) err_set = 1'b1;
        if (stop) begin
          state_d   = ST_ARMED;
          phase_d   = '0;
          key_out_d = '0;
        end else begin
          phase_d   = phase_inc;
          key_out_d = table_q[phase_inc];
          if (phase_q == IDX_W'(DEPTH - 1) && wraps_q != '1)
            wraps_d = wraps_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_LOAD;
        phase_d   = '0;
        key_out_d = '0;
      end
    endcase

    // Status outputs are registered copies of the next state.
    cfg_ready_d = (state_d != ST_RUN);
    armed_d     = (state_d == ST_ARMED);
    busy_d      = (state_d == ST_RUN);
    key_valid_d = (state_d == ST_RUN);
    // A set event in the same cycle as a clear keeps the flag raised.
    err_d       = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // State and registered outputs; reset forces LOAD from any state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      cfg_ready_q <= 1'b1;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      phase_q     <= '0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      wraps_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      phase_q     <= phase_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      wraps_q     <= wraps_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign phase     = phase_q;
  assign armed     = armed_q;
  assign busy      = busy_q;
  assign wraps     = wraps_q;
  assign err       = err_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Testbench for key_schedule_ctrl: scenario tasks with a queue of expected
// RUN-cycle outputs built from a local copy of the schedule.
module tb_key_schedule_ctrl;

  localparam int KEY_W  = 3;
  localparam int DEPTH  = 4;
  localparam int IDX_W  = 2;
  localparam int WRAP_W = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [IDX_W-1:0]  cfg_idx;
  logic [KEY_W-1:0]  cfg_key;
  logic              cfg_commit;
  logic              start;
  logic              stop;
  logic              err_clr;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic [IDX_W-1:0]  phase;
  logic              armed;
  logic              busy;
  logic [WRAP_W-1:0] wraps;
  logic              err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [IDX_W-1:0]  ph;
    logic [KEY_W-1:0]  key;
    logic [WRAP_W-1:0] wr;
  } exp_t;

  exp_t             sb_q[$];
  logic [KEY_W-1:0] model_tbl [DEPTH];

  key_schedule_ctrl #(
    .KEY_W(KEY_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .WRAP_W(WRAP_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_key(cfg_key), .cfg_commit(cfg_commit),
    .start(start), .stop(stop), .err_clr(err_clr),
    .key_out(key_out), .key_valid(key_valid), .phase(phase),
    .armed(armed), .busy(busy), .wraps(wraps), .err(err)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are stable 1ns after the edge, and inputs
  // driven afterwards are sampled at the following edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_entry(input logic [IDX_W-1:0] idx, input logic [KEY_W-1:0] k);
    cfg_valid = 1'b1; cfg_idx = idx; cfg_key = k;
    step();
    cfg_valid = 1'b0;
    model_tbl[idx] = k;
    $display("write idx=%0d key=%b", idx, k);
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
    $display("commit armed=%0b err=%0b", armed, err);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
    $display("start phase=%0d key=%b", phase, key_out);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = '0;
  endtask

  // Queue n consecutive RUN cycles starting at phase p0 with wrap count w0.
  task automatic push_run(input int p0, input int w0, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ph  = IDX_W'((p0 + k) % DEPTH);
      e.key = model_tbl[(p0 + k) % DEPTH];
      e.wr  = WRAP_W'(w0 + (p0 + k) / DEPTH);
      sb_q.push_back(e);
    end
  endtask

  // Pop and compare queued RUN cycles, stepping after each one.
  task automatic drain_run(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (key_out !== e.key || phase !== e.ph || wraps !== e.wr ||
          busy !== 1'b1 || key_valid !== 1'b1) begin
        bad++;
        $display("FAIL %s run: got key=%b ph=%0d wr=%0d busy=%0b kv=%0b exp key=%b ph=%0d wr=%0d busy=1 kv=1",
                 tag, key_out, phase, wraps, busy, key_valid, e.key, e.ph, e.wr);
      end else begin
        $display("%s run ph=%0d key=%b wr=%0d", tag, phase, key_out, wraps);
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({key_out, key_valid, phase, armed, busy, wraps, err} !== '0) begin
      bad++;
      $display("FAIL reset: got key=%b kv=%0b ph=%0d armed=%0b busy=%0b wr=%0d err=%0b exp all 0",
               key_out, key_valid, phase, armed, busy, wraps, err);
    end else $display("reset outputs zero");
  endtask

  task automatic test_load_commit();
    wr_entry(2'd0, 3'b100);
    wr_entry(2'd1, 3'b000);
    wr_entry(2'd2, 3'b011);
    wr_entry(2'd3, 3'b110);
    total++;
    if (cfg_ready !== 1'b1 || armed !== 1'b0) begin
      bad++;
      $display("FAIL load: got ready=%0b armed=%0b exp ready=1 armed=0", cfg_ready, armed);
    end
    pulse_commit();
    total++;
    if (armed !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL commit: got armed=%0b err=%0b busy=%0b exp 1 0 0", armed, err, busy);
    end
  endtask

  task automatic test_run_sequence();
    pulse_start();
    push_run(0, 0, 9);
    drain_run("seq");
    // Now in the 10th RUN cycle (phase 1, wraps 2); stop returns to ARMED.
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (key_out !== '0 || key_valid !== 1'b0 || phase !== '0 || armed !== 1'b1 ||
        busy !== 1'b0 || wraps !== 16'd2) begin
      bad++;
      $display("FAIL stop: got key=%b kv=%0b ph=%0d armed=%0b busy=%0b wr=%0d exp 0 0 0 1 0 2",
               key_out, key_valid, phase, armed, busy, wraps);
    end else $display("stop armed wr=%0d", wraps);
  endtask

  task automatic test_incomplete();
    do_reset();
    wr_entry(2'd0, 3'b101);
    wr_entry(2'd1, 3'b010);
    wr_entry(2'd2, 3'b111);
    pulse_commit();
    total++;
    if (err !== 1'b1 || armed !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL incomplete: got err=%0b armed=%0b ready=%0b exp 1 0 1", err, armed, cfg_ready);
    end
    wr_entry(2'd3, 3'b001);
    pulse_err_clr();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got err=%0b exp 0", err);
    end
    pulse_commit();
    total++;
    if (armed !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL recommit: got armed=%0b err=%0b exp 1 0", armed, err);
    end
    // start outside ARMED is flagged: check via LOAD after a rewrite.
    wr_entry(2'd3, 3'b011);
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL rewrite: got armed=%0b exp 0", armed);
    end
    pulse_start();
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL start_in_load: got err=%0b busy=%0b exp 1 0", err, busy);
    end
    pulse_err_clr();
    pulse_commit();
  endtask

  task automatic test_cfg_in_run();
    pulse_start();
    push_run(0, 0, 2);
    drain_run("pre");
    // Phase 2 is visible now.
    total++;
    if (cfg_ready !== 1'b0 || phase !== 2'd2) begin
      bad++;
      $display("FAIL ready_in_run: got ready=%0b ph=%0d exp 0 2", cfg_ready, phase);
    end
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_key = 3'b110;
    step();
    cfg_valid = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL cfg_in_run err: got %0b exp 1", err);
    end
    // Table must be unchanged: model_tbl is not updated.
    push_run(3, 0, 5);
    drain_run("cfgrun");
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    total++;
    if (armed !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0 || key_out !== '0 || phase !== '0) begin
      bad++;
      $display("FAIL start_stop: got armed=%0b busy=%0b kv=%0b key=%b ph=%0d exp 1 0 0 0 0",
               armed, busy, key_valid, key_out, phase);
    end else $display("start+stop -> armed");
    pulse_start();
    push_run(0, 0, 3);
    drain_run("restart");
  endtask

  task automatic test_reset_midrun();
    int guard = 0;
    while (phase !== 2'd3 && guard < 8) begin
      step();
      guard++;
    end
    total++;
    if (phase !== 2'd3) begin
      bad++;
      $display("FAIL wait_phase3: got ph=%0d exp 3", phase);
    end
    do_reset();
    total++;
    if ({key_out, key_valid, phase, armed, busy, wraps, err} !== '0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrun_reset: got key=%b kv=%0b ph=%0d armed=%0b busy=%0b wr=%0d err=%0b ready=%0b exp 0s ready=1",
               key_out, key_valid, phase, armed, busy, wraps, err, cfg_ready);
    end
    pulse_commit();
    total++;
    if (err !== 1'b1 || armed !== 1'b0) begin
      bad++;
      $display("FAIL mask_cleared: got err=%0b armed=%0b exp 1 0", err, armed);
    end
  endtask

  initial begin
    reset_n = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_key = '0;
    cfg_commit = 1'b0; start = 1'b0; stop = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = '0;
    step();
    test_reset();
    test_load_commit();
    test_run_sequence();
    test_incomplete();
    test_cfg_in_run();
    test_start_stop();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
